lsb_mem_port: RTL and testbench

LSB_MEM_PORT -- requirements
Module: lsb_mem_port

---
 rtl/lsb_mem_port.sv | 188 ++++++++++++++++++
 tb/tb_lsb_mem_port.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_mem_port.sv
// Load/store unit memory port: splits one 1/2/4-byte request into single-byte
// dcache requests, gathers read bytes in order, and extends the load result.
module lsb_mem_port #(
  parameter int TAG_W = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic             req_wr_in,
  input  logic [1:0]       req_size_in,
  input  logic             req_signed_in,
  input  logic [31:0]      req_addr_in,
  input  logic [31:0]      req_data_in,
  input  logic [TAG_W-1:0] req_tag_in,
  output logic             byte_req_valid_out,
  input  logic             byte_req_ready_in,
  output logic             byte_req_wr_out,
  output logic [31:0]      byte_req_addr_out,
  output logic [7:0]       byte_req_data_out,
  input  logic             byte_rsp_valid_in,
  input  logic [7:0]       byte_rsp_data_in,
  output logic             done_out,
  output logic [TAG_W-1:0] done_tag_out,
  output logic [31:0]      done_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2:0]       n_q, n_d;
  logic [2:0]       issue_cnt_q, issue_cnt_d;
  logic [2:0]       rsp_cnt_q, rsp_cnt_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;
  logic [TAG_W-1:0] done_tag_q, done_tag_d;
  logic [31:0]      done_data_q, done_data_d;

  logic accept;
  logic byte_fire;
  logic last_issue;
  logic rsp_take;

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    case (size)
      2'd0:    return {{24{sgn & raw[7]}}, raw[7:0]};
      2'd1:    return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    req_ready_out      = (state_q == IDLE);
    byte_req_valid_out = (state_q == ISSUE) && rdy_in;
    byte_req_wr_out    = (state_q == ISSUE) && wr_q;
    byte_req_addr_out  = (state_q == ISSUE) ? addr_q + {29'd0, issue_cnt_q} : 32'd0;
    byte_req_data_out  = (state_q == ISSUE && wr_q) ?
                         data_q[{issue_cnt_q[1:0], 3'b000} +: 8] : 8'd0;
    done_out           = done_q;
    done_tag_out       = done_tag_q;
    done_data_out      = done_data_q;
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tag_d       = tag_q;
    n_d         = n_q;
    issue_cnt_d = issue_cnt_q;
    rsp_cnt_d   = rsp_cnt_q;
    result_d    = result_q;
    done_d      = 1'b0;
    done_tag_d  = done_tag_q;
    done_data_d = done_data_q;

    accept     = (state_q == IDLE) && req_valid_in && rdy_in;
    byte_fire  = byte_req_valid_out && byte_req_ready_in;
    last_issue = byte_fire && (issue_cnt_q == n_q - 3'd1);

    // Read bytes are collected regardless of rdy_in so none are lost while frozen
    rsp_take = byte_rsp_valid_in && !wr_q && (rsp_cnt_q < n_q) &&
               (state_q == ISSUE || state_q == WAIT_RD);
    if (rsp_take) begin
      result_d[{rsp_cnt_q[1:0], 3'b000} +: 8] = byte_rsp_data_in;
      rsp_cnt_d = rsp_cnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d        = req_wr_in;
          size_d      = req_size_in;
          sgn_d       = req_signed_in;
          addr_d      = req_addr_in;
          data_d      = req_data_in;
          tag_d       = req_tag_in;
          issue_cnt_d = 3'd0;
          rsp_cnt_d   = 3'd0;
          result_d    = 32'd0;
          case (req_size_in)
            2'd0:    n_d = 3'd1;
            2'd1:    n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (byte_fire) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
        if (last_issue) begin
          if (wr_q || rsp_cnt_d == n_q) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (rdy_in && rsp_cnt_d == n_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rdy_in) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion is registered on entry to DONE so the final byte is included
    if (state_d == DONE && state_q != DONE) begin
      done_d      = 1'b1;
      done_tag_d  = tag_q;
      done_data_d = wr_q ? 32'd0 : extend_load(result_d, size_q, sgn_q);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      tag_q       <= '0;
      n_q         <= 3'd0;
      issue_cnt_q <= 3'd0;
      rsp_cnt_q   <= 3'd0;
      result_q    <= 32'd0;
      done_q      <= 1'b0;
      done_tag_q  <= '0;
      done_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      n_q         <= n_d;
      issue_cnt_q <= issue_cnt_d;
      rsp_cnt_q   <= rsp_cnt_d;
      result_q    <= result_d;
      done_q      <= done_d;
      done_tag_q  <= done_tag_d;
      done_data_q <= done_data_d;
    end
  end

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port: byte splitting, load extension, stalls,
// rdy_in freeze and mid-operation reset.
module tb_lsb_mem_port;
  localparam int TAG_W = 3;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             rdy_in;
  logic             req_valid_in;
  logic             req_ready_out;
  logic             req_wr_in;
  logic [1:0]       req_size_in;
  logic             req_signed_in;
  logic [31:0]      req_addr_in;
  logic [31:0]      req_data_in;
  logic [TAG_W-1:0] req_tag_in;
  logic             byte_req_valid_out;
  logic             byte_req_ready_in;
  logic             byte_req_wr_out;
  logic [31:0]      byte_req_addr_out;
  logic [7:0]       byte_req_data_out;
  logic             byte_rsp_valid_in;
  logic [7:0]       byte_rsp_data_in;
  logic             done_out;
  logic [TAG_W-1:0] done_tag_out;
  logic [31:0]      done_data_out;

  int compared   = 0;
  int mismatched = 0;

  lsb_mem_port #(.TAG_W(TAG_W)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .rdy_in             (rdy_in),
    .req_valid_in       (req_valid_in),
    .req_ready_out      (req_ready_out),
    .req_wr_in          (req_wr_in),
    .req_size_in        (req_size_in),
    .req_signed_in      (req_signed_in),
    .req_addr_in        (req_addr_in),
    .req_data_in        (req_data_in),
    .req_tag_in         (req_tag_in),
    .byte_req_valid_out (byte_req_valid_out),
    .byte_req_ready_in  (byte_req_ready_in),
    .byte_req_wr_out    (byte_req_wr_out),
    .byte_req_addr_out  (byte_req_addr_out),
    .byte_req_data_out  (byte_req_data_out),
    .byte_rsp_valid_in  (byte_rsp_valid_in),
    .byte_rsp_data_in   (byte_rsp_data_in),
    .done_out           (done_out),
    .done_tag_out       (done_tag_out),
    .done_data_out      (done_data_out)
  );

  always #5 clk_in = ~clk_in;

  // Single point of comparison so every check is counted the same way
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs always change 1ns after the rising edge; outputs are read on the falling edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [TAG_W-1:0] tag);
    req_valid_in  = 1'b1;
    req_wr_in     = wr;
    req_size_in   = size;
    req_signed_in = sgn;
    req_addr_in   = addr;
    req_data_in   = data;
    req_tag_in    = tag;
    @(negedge clk_in);
    checkOutput("req_ready at accept", {31'd0, req_ready_out}, 32'd1);
    tick();
    req_valid_in = 1'b0;
  endtask

  task automatic waitDone(input string name, input logic [TAG_W-1:0] tag,
                          input logic [31:0] data, input int expWait);
    bit found = 1'b0;
    int waited = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if (done_out) begin
        found = 1'b1;
        waited = i;
        break;
      end
      tick();
    end
    checkOutput({name, " done seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      checkOutput({name, " latency"}, waited, expWait);
      checkOutput({name, " tag"}, {29'd0, done_tag_out}, {29'd0, tag});
      checkOutput({name, " data"}, done_data_out, data);
      tick();
      @(negedge clk_in);
      checkOutput({name, " single pulse"}, {31'd0, done_out}, 32'd0);
      checkOutput({name, " data held"}, done_data_out, data);
      checkOutput({name, " ready after"}, {31'd0, req_ready_out}, 32'd1);
    end
    tick();
  endtask

  task automatic sendRsp(input logic [7:0] value);
    byte_rsp_valid_in = 1'b1;
    byte_rsp_data_in  = value;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] storeBytes [4];
    logic [7:0] store2Bytes [4];
    int doneCount;

    storeBytes  = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    store2Bytes = '{8'h88, 8'h77, 8'h66, 8'h55};

    rst_n_in          = 1'b0;
    rdy_in            = 1'b1;
    req_valid_in      = 1'b0;
    req_wr_in         = 1'b0;
    req_size_in       = 2'd0;
    req_signed_in     = 1'b0;
    req_addr_in       = 32'd0;
    req_data_in       = 32'd0;
    req_tag_in        = '0;
    byte_req_ready_in = 1'b1;
    byte_rsp_valid_in = 1'b0;
    byte_rsp_data_in  = 8'd0;

    // Reset state
    repeat (2) @(negedge clk_in);
    checkOutput("reset req_ready", {31'd0, req_ready_out}, 32'd1);
    checkOutput("reset byte valid", {31'd0, byte_req_valid_out}, 32'd0);
    checkOutput("reset byte wr", {31'd0, byte_req_wr_out}, 32'd0);
    checkOutput("reset byte addr", byte_req_addr_out, 32'd0);
    checkOutput("reset byte data", {24'd0, byte_req_data_out}, 32'd0);
    checkOutput("reset done", {31'd0, done_out}, 32'd0);
    checkOutput("reset done data", done_data_out, 32'd0);
    tick();
    rst_n_in = 1'b1;
    tick();

    // Word store at 0x1000: bytes in cycles 1-4, done in cycle 5
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hA1B2_C3D4, 3'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      checkOutput($sformatf("wstore b%0d valid", i), {31'd0, byte_req_valid_out}, 32'd1);
      checkOutput($sformatf("wstore b%0d wr", i), {31'd0, byte_req_wr_out}, 32'd1);
      checkOutput($sformatf("wstore b%0d addr", i), byte_req_addr_out, 32'h0000_1000 + i);
      checkOutput($sformatf("wstore b%0d data", i), {24'd0, byte_req_data_out},
                  {24'd0, storeBytes[i]});
      tick();
    end
    waitDone("wstore", 3'd5, 32'h0000_0000, 0);

    // Signed byte load 0x80
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 3'd2);
    @(negedge clk_in);
    checkOutput("sbload addr", byte_req_addr_out, 32'h0000_0020);
    checkOutput("sbload wr", {31'd0, byte_req_wr_out}, 32'd0);
    checkOutput("sbload data zero", {24'd0, byte_req_data_out}, 32'd0);
    tick();
    sendRsp(8'h80);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("sbload", 3'd2, 32'hFFFF_FF80, 0);

    // Unsigned byte load 0x80
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'd0, 3'd3);
    tick();
    sendRsp(8'h80);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("ubload", 3'd3, 32'h0000_0080, 0);

    // Response in the same cycle as the only issue goes straight to DONE
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h0000_0040, 32'd0, 3'd4);
    sendRsp(8'h7F);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("sameload", 3'd4, 32'h0000_007F, 0);

    // Signed half load wrapping the address space
    applyStimulus(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 3'd1);
    @(negedge clk_in);
    checkOutput("hwrap b0 addr", byte_req_addr_out, 32'hFFFF_FFFF);
    tick();
    sendRsp(8'h34);
    @(negedge clk_in);
    checkOutput("hwrap b1 addr", byte_req_addr_out, 32'h0000_0000);
    tick();
    sendRsp(8'h92);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("hwrap", 3'd1, 32'hFFFF_9234, 0);

    // Word load with byte 1 stalled 3 cycles and an early response
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'd0, 3'd6);
    @(negedge clk_in);
    checkOutput("stall b0 addr", byte_req_addr_out, 32'h0000_0200);
    tick();
    byte_req_ready_in = 1'b0;
    sendRsp(8'h11);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      checkOutput($sformatf("stall hold%0d valid", k), {31'd0, byte_req_valid_out}, 32'd1);
      checkOutput($sformatf("stall hold%0d addr", k), byte_req_addr_out, 32'h0000_0201);
      tick();
      byte_rsp_valid_in = 1'b0;
    end
    byte_req_ready_in = 1'b1;
    sendRsp(8'h22);
    @(negedge clk_in);
    checkOutput("stall b1 addr", byte_req_addr_out, 32'h0000_0201);
    tick();
    byte_rsp_valid_in = 1'b0;
    @(negedge clk_in);
    checkOutput("stall b2 addr", byte_req_addr_out, 32'h0000_0202);
    tick();
    sendRsp(8'h33);
    @(negedge clk_in);
    checkOutput("stall b3 addr", byte_req_addr_out, 32'h0000_0203);
    tick();
    sendRsp(8'h44);
    @(negedge clk_in);
    checkOutput("stall waitrd ready", {31'd0, req_ready_out}, 32'd0);
    checkOutput("stall waitrd valid", {31'd0, byte_req_valid_out}, 32'd0);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("stall", 3'd6, 32'h4433_2211, 0);

    // Word store with rdy_in low for 2 cycles after byte 0
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'h5566_7788, 3'd1);
    @(negedge clk_in);
    checkOutput("frz b0 data", {24'd0, byte_req_data_out}, {24'd0, store2Bytes[0]});
    tick();
    rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_in);
      checkOutput($sformatf("frz low%0d valid", k), {31'd0, byte_req_valid_out}, 32'd0);
      tick();
    end
    rdy_in = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk_in);
      checkOutput($sformatf("frz b%0d addr", i), byte_req_addr_out, 32'h0000_3000 + i);
      checkOutput($sformatf("frz b%0d data", i), {24'd0, byte_req_data_out},
                  {24'd0, store2Bytes[i]});
      tick();
    end
    waitDone("frz", 3'd1, 32'h0000_0000, 0);

    // Spurious response while idle
    sendRsp(8'hEE);
    @(negedge clk_in);
    checkOutput("idle rsp ready", {31'd0, req_ready_out}, 32'd1);
    tick();
    byte_rsp_valid_in = 1'b0;
    @(negedge clk_in);
    checkOutput("idle rsp no done", {31'd0, done_out}, 32'd0);
    tick();
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h0000_0050, 32'd0, 3'd7);
    tick();
    sendRsp(8'h12);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("after idle rsp", 3'd7, 32'h0000_0012, 0);

    // Reset during WAIT_RD abandons the load
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h0000_0060, 32'd0, 3'd3);
    repeat (4) tick();
    sendRsp(8'hAA);
    @(negedge clk_in);
    checkOutput("rst waitrd ready", {31'd0, req_ready_out}, 32'd0);
    tick();
    byte_rsp_valid_in = 1'b0;
    rst_n_in = 1'b0;
    @(negedge clk_in);
    checkOutput("midrst ready", {31'd0, req_ready_out}, 32'd1);
    checkOutput("midrst valid", {31'd0, byte_req_valid_out}, 32'd0);
    checkOutput("midrst done", {31'd0, done_out}, 32'd0);
    checkOutput("midrst done data", done_data_out, 32'd0);
    tick();
    rst_n_in = 1'b1;
    sendRsp(8'h99);
    doneCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      if (done_out) doneCount++;
      tick();
      byte_rsp_valid_in = 1'b0;
    end
    checkOutput("midrst no completion", doneCount, 32'd0);
    checkOutput("midrst ready after", {31'd0, req_ready_out}, 32'd1);

    // Recovery: unsigned half load
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h0000_0070, 32'd0, 3'd2);
    tick();
    sendRsp(8'hCD);
    tick();
    sendRsp(8'hAB);
    tick();
    byte_rsp_valid_in = 1'b0;
    waitDone("recover", 3'd2, 32'h0000_ABCD, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
